// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states
// and the legal-opcode check. Optional statistics: ALU_SEQ_STATS_EN.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_EQ  = 6'b110000;
    localparam logic [5:0] OP_NE  = 6'b110001;
    localparam logic [5:0] OP_LE  = 6'b110010;
    localparam logic [5:0] OP_GT  = 6'b110011;
    localparam logic [5:0] OP_LLS = 6'b111000;
    localparam logic [5:0] OP_LRS = 6'b111001;
    localparam logic [5:0] OP_ARS = 6'b111010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } seq_state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE,
            OP_GT, OP_LLS, OP_LRS, OP_ARS: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and response signals of the sequencer.
// slave = sequencer side, master = environment (producer, ALU, consumer).
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_use_acc;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_ans1;
    logic              alu_ans2;
    logic              alu_z;
    logic              alu_n;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
    logic              rsp_z;
    logic              rsp_n;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output alu_ans1, alu_ans2, alu_z, alu_n, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_data, rsp_carry, rsp_z, rsp_n, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  alu_ans1, alu_ans2, alu_z, alu_n, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
        output rsp_valid, rsp_data, rsp_carry, rsp_z, rsp_n, rsp_err
    );

endinterface

// File: rtl/alu_seq_stats.sv
// Saturating pair of completion/rejection counters for the sequencer.
// Instantiated only when ALU_SEQ_STATS_EN is defined.
module alu_seq_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_ops,
    input  logic             inc_err,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_err
);

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops <= '0;
            stat_err <= '0;
        end else begin
            if (inc_ops && (stat_ops != '1))
                stat_ops <= stat_ops + 1'b1;
            if (inc_err && (stat_err != '1))
                stat_err <= stat_err + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU command sequencer with result accumulator.
// Optional statistics counters: define ALU_SEQ_STATS_EN.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6,
    parameter int ALU_LAT = 1
`ifdef ALU_SEQ_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_err
`endif
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0] LAST = LAT_W'(ALU_LAT - 1);

    seq_state_t        state;
    logic [LAT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
    logic              rsp_z;
    logic              rsp_n;
    logic              rsp_err;
    logic              legal;
    logic              capture;
    logic              reject;

    assign legal   = is_legal_op(bus.cmd_op);
    assign capture = (state == S_EXEC) && (cnt == LAST);
    assign reject  = (state == S_IDLE) && bus.cmd_valid && !legal;

    // Sequencer FSM; ALU drive and response fields are all registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_z     <= 1'b0;
            rsp_n     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && legal) begin
                        alu_a  <= bus.cmd_use_acc ? acc : bus.cmd_a;
                        alu_b  <= bus.cmd_b;
                        alu_op <= bus.cmd_op;
                        cnt    <= '0;
                        state  <= S_EXEC;
                    end else if (bus.cmd_valid) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_z     <= 1'b0;
                        rsp_n     <= 1'b0;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_EXEC: begin
                    if (capture) begin
                        rsp_data  <= bus.alu_ans1;
                        rsp_carry <= bus.alu_ans2;
                        rsp_z     <= bus.alu_z;
                        rsp_n     <= bus.alu_n;
                        rsp_err   <= 1'b0;
                        acc       <= bus.alu_ans1;
                        alu_a     <= '0;
                        alu_b     <= '0;
                        alu_op    <= '0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_z     <= 1'b0;
                        rsp_n     <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_op    = alu_op;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_carry = rsp_carry;
    assign bus.rsp_z     = rsp_z;
    assign bus.rsp_n     = rsp_n;
    assign bus.rsp_err   = rsp_err;

`ifdef ALU_SEQ_STATS_EN
    alu_seq_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .inc_ops (capture),
        .inc_err (reject),
        .stat_ops(stat_ops),
        .stat_err(stat_err)
    );
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (ALU_LAT=1 and 3) each paired with a
// behavioural ALU. Statistics checks built when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_W(32), .OP_W(6)) bus1 ();
    alu_op_sequencer_if #(.DATA_W(32), .OP_W(6)) bus3 ();

`ifdef ALU_SEQ_STATS_EN
    logic [1:0]  stat_ops1, stat_err1;
    logic [15:0] stat_ops3, stat_err3;
`endif

    alu_op_sequencer #(
        .DATA_W(32), .OP_W(6), .ALU_LAT(1)
`ifdef ALU_SEQ_STATS_EN
        , .CNT_W(2)
`endif
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
`ifdef ALU_SEQ_STATS_EN
        , .stat_ops(stat_ops1), .stat_err(stat_err1)
`endif
    );

    alu_op_sequencer #(
        .DATA_W(32), .OP_W(6), .ALU_LAT(3)
`ifdef ALU_SEQ_STATS_EN
        , .CNT_W(16)
`endif
    ) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
`ifdef ALU_SEQ_STATS_EN
        , .stat_ops(stat_ops3), .stat_err(stat_err3)
`endif
    );

    // Behavioural ALU: returns {n, z, carry, result}
    function automatic logic [34:0] alu_model(input logic [5:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        r = '0;
        c = 1'b0;
        s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_EQ:  r = {31'b0, a == b};
            OP_NE:  r = {31'b0, a != b};
            OP_LE:  r = {31'b0, a <= b};
            OP_GT:  r = {31'b0, a > b};
            OP_LLS: r = a << b[4:0];
            OP_LRS: r = a >> b[4:0];
            OP_ARS: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        return {r[31], r == 32'd0, c, r};
    endfunction

    assign {bus1.alu_n, bus1.alu_z, bus1.alu_ans2, bus1.alu_ans1} =
        alu_model(bus1.alu_op, bus1.alu_a, bus1.alu_b);
    assign {bus3.alu_n, bus3.alu_z, bus3.alu_ans2, bus3.alu_ans1} =
        alu_model(bus3.alu_op, bus3.alu_a, bus3.alu_b);

    task automatic send1(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ua);
        int n = 0;
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op = op;
        bus1.cmd_a = a;
        bus1.cmd_b = b;
        bus1.cmd_use_acc = ua;
        while (!bus1.cmd_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus1.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept1 cmd_ready=%0b want 1", bus1.cmd_ready);
        end
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
    endtask

    task automatic send3(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ua);
        int n = 0;
        bus3.cmd_valid = 1'b1;
        bus3.cmd_op = op;
        bus3.cmd_a = a;
        bus3.cmd_b = b;
        bus3.cmd_use_acc = ua;
        while (!bus3.cmd_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus3.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept3 cmd_ready=%0b want 1", bus3.cmd_ready);
        end
        @(posedge clk); #1;
        bus3.cmd_valid = 1'b0;
    endtask

    task automatic wait1(output int e);
        e = 0;
        while (!bus1.rsp_valid && e < 30) begin
            @(posedge clk); #1; e++;
        end
    endtask

    task automatic wait3(output int e);
        e = 0;
        while (!bus3.rsp_valid && e < 30) begin
            @(posedge clk); #1; e++;
        end
    endtask

    task automatic ack1();
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic ack3();
        bus3.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus3.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus1.cmd_ready !== 1'b1 || bus1.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%0b valid=%0b want 1 0",
                     bus1.cmd_ready, bus1.rsp_valid);
        end
        checks++;
        if (bus1.alu_a !== 0 || bus1.alu_b !== 0 || bus1.alu_op !== 0) begin
            errors++;
            $display("FAIL reset_alu a=%h b=%h op=%h want 0",
                     bus1.alu_a, bus1.alu_b, bus1.alu_op);
        end
        checks++;
        if (bus1.rsp_data !== 0 || bus1.rsp_err !== 0 ||
            bus1.rsp_carry !== 0 || bus1.rsp_z !== 0 || bus1.rsp_n !== 0) begin
            errors++;
            $display("FAIL reset_rsp data=%h err=%0b want 0",
                     bus1.rsp_data, bus1.rsp_err);
        end
        checks++;
        if (bus3.cmd_ready !== 1'b1 || bus3.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut3 ready=%0b valid=%0b want 1 0",
                     bus3.cmd_ready, bus3.rsp_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ne();
        int e;
        send1(OP_NE, 32'h0001_0000, 32'h0000_0001, 1'b0);
        checks++;
        if (bus1.alu_op !== OP_NE || bus1.alu_a !== 32'h0001_0000 ||
            bus1.alu_b !== 32'h1) begin
            errors++;
            $display("FAIL ne_drive op=%h a=%h b=%h want 31 00010000 1",
                     bus1.alu_op, bus1.alu_a, bus1.alu_b);
        end
        wait1(e);
        checks++;
        if (e !== 1) begin
            errors++;
            $display("FAIL ne_latency edges=%0d want 1", e);
        end
        checks++;
        if (bus1.rsp_data !== 32'h1 || bus1.rsp_z !== 1'b0 ||
            bus1.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ne_rsp data=%h z=%0b err=%0b want 1 0 0",
                     bus1.rsp_data, bus1.rsp_z, bus1.rsp_err);
        end
        checks++;
        if (bus1.alu_op !== 0) begin
            errors++;
            $display("FAIL ne_alu_idle op=%h want 0", bus1.alu_op);
        end
        ack1();
    endtask

    task automatic test_add_acc();
        int e;
        send1(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
        wait1(e);
        checks++;
        if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== 32'h0 ||
            bus1.rsp_carry !== 1'b1 || bus1.rsp_z !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap v=%0b data=%h c=%0b z=%0b want 1 0 1 1",
                     bus1.rsp_valid, bus1.rsp_data, bus1.rsp_carry, bus1.rsp_z);
        end
        ack1();
        send1(OP_ADD, 32'h1234_5678, 32'h5, 1'b1);
        wait1(e);
        checks++;
        if (bus1.rsp_data !== 32'h5 || bus1.rsp_carry !== 1'b0 ||
            bus1.rsp_z !== 1'b0) begin
            errors++;
            $display("FAIL add_acc data=%h c=%0b z=%0b want 5 0 0",
                     bus1.rsp_data, bus1.rsp_carry, bus1.rsp_z);
        end
        ack1();
    endtask

    task automatic test_illegal();
        int e;
        send1(6'b000000, 32'h7, 32'h9, 1'b0);
        checks++;
        if (bus1.alu_op !== 0 || bus1.alu_a !== 0 || bus1.alu_b !== 0) begin
            errors++;
            $display("FAIL ill_alu op=%h a=%h b=%h want 0",
                     bus1.alu_op, bus1.alu_a, bus1.alu_b);
        end
        wait1(e);
        checks++;
        if (bus1.rsp_valid !== 1'b1 || bus1.rsp_err !== 1'b1 ||
            bus1.rsp_data !== 0 || bus1.rsp_z !== 0 || bus1.rsp_carry !== 0) begin
            errors++;
            $display("FAIL ill_rsp v=%0b err=%0b data=%h want 1 1 0",
                     bus1.rsp_valid, bus1.rsp_err, bus1.rsp_data);
        end
        ack1();
        send1(OP_ADD, 32'hDEAD_BEEF, 32'h2, 1'b1);
        wait1(e);
        checks++;
        if (bus1.rsp_data !== 32'h7 || bus1.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ill_acc data=%h err=%0b want 7 0",
                     bus1.rsp_data, bus1.rsp_err);
        end
        ack1();
    endtask

    task automatic test_ops();
        logic [5:0]  op_t [6] = '{OP_LLS, OP_LRS, OP_ARS, OP_GT, OP_LE, OP_SUB};
        logic [31:0] a_t  [6] = '{32'h1, 32'h100, 32'h8000_0000,
                                  32'h5, 32'h5, 32'h3};
        logic [31:0] b_t  [6] = '{32'h4, 32'h4, 32'h4, 32'h3, 32'h3, 32'h5};
        logic [31:0] d_t  [6] = '{32'h10, 32'h10, 32'hF800_0000,
                                  32'h1, 32'h0, 32'hFFFF_FFFE};
        logic [2:0]  f_t  [6] = '{3'b000, 3'b000, 3'b100,
                                  3'b000, 3'b010, 3'b101};
        int e;
        for (int i = 0; i < 6; i++) begin
            send1(op_t[i], a_t[i], b_t[i], 1'b0);
            wait1(e);
            checks++;
            if (bus1.rsp_data !== d_t[i] ||
                {bus1.rsp_n, bus1.rsp_z, bus1.rsp_carry} !== f_t[i]) begin
                errors++;
                $display("FAIL op_%0d data=%h nzc=%b want %h %b", i,
                         bus1.rsp_data, {bus1.rsp_n, bus1.rsp_z, bus1.rsp_carry},
                         d_t[i], f_t[i]);
            end
            ack1();
        end
    endtask

    task automatic test_backpressure();
        int e;
        send1(OP_SUB, 32'd10, 32'd3, 1'b0);
        wait1(e);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op = OP_EQ;
        bus1.cmd_a = 32'd4;
        bus1.cmd_b = 32'd4;
        bus1.cmd_use_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus1.rsp_valid !== 1'b1 || bus1.rsp_data !== 32'd7 ||
                bus1.cmd_ready !== 1'b0 || bus1.alu_op !== 0) begin
                errors++;
                $display("FAIL stall_%0d v=%0b data=%h rdy=%0b op=%h want 1 7 0 0",
                         i, bus1.rsp_valid, bus1.rsp_data,
                         bus1.cmd_ready, bus1.alu_op);
            end
        end
        bus1.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus1.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bubble cmd_ready=%0b want 0", bus1.cmd_ready);
        end
        @(posedge clk); #1;
        bus1.rsp_ready = 1'b0;
        checks++;
        if (bus1.cmd_ready !== 1'b1 || bus1.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_hs rdy=%0b v=%0b want 1 0",
                     bus1.cmd_ready, bus1.rsp_valid);
        end
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        checks++;
        if (bus1.alu_op !== OP_EQ || bus1.alu_a !== 32'd4) begin
            errors++;
            $display("FAIL late_accept op=%h a=%h want 30 4",
                     bus1.alu_op, bus1.alu_a);
        end
        wait1(e);
        checks++;
        if (bus1.rsp_data !== 32'd1 || bus1.rsp_z !== 1'b0) begin
            errors++;
            $display("FAIL late_rsp data=%h z=%0b want 1 0",
                     bus1.rsp_data, bus1.rsp_z);
        end
        ack1();
    endtask

    task automatic test_throughput();
        int acc_n = 0;
        bus1.rsp_ready = 1'b1;
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op = OP_ADD;
        bus1.cmd_a = 32'd1;
        bus1.cmd_b = 32'd1;
        bus1.cmd_use_acc = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (bus1.cmd_ready && bus1.cmd_valid) acc_n++;
            @(posedge clk); #1;
        end
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b0;
        checks++;
        if (acc_n !== 3 || bus1.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL throughput accepts=%0d rdy=%0b want 3 1",
                     acc_n, bus1.cmd_ready);
        end
    endtask

    task automatic test_lat3();
        int e;
        send3(OP_ADD, 32'd2, 32'd3, 1'b0);
        wait3(e);
        checks++;
        if (e !== 3) begin
            errors++;
            $display("FAIL lat3 edges=%0d want 3", e);
        end
        checks++;
        if (bus3.rsp_data !== 32'd5 || bus3.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL lat3_rsp data=%h err=%0b want 5 0",
                     bus3.rsp_data, bus3.rsp_err);
        end
        ack3();
    endtask

    task automatic test_reset_exec();
        int e;
        send3(OP_ADD, 32'd100, 32'd1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus3.alu_a !== 32'd100 || bus3.alu_op !== OP_ADD) begin
            errors++;
            $display("FAIL exec_hold a=%h op=%h want 64 20",
                     bus3.alu_a, bus3.alu_op);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus3.alu_a !== 0 || bus3.alu_b !== 0 || bus3.alu_op !== 0 ||
            bus3.rsp_valid !== 1'b0 || bus3.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst a=%h op=%h v=%0b rdy=%0b want 0 0 0 1",
                     bus3.alu_a, bus3.alu_op, bus3.rsp_valid, bus3.cmd_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus3.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_rsp v=%0b want 0", bus3.rsp_valid);
        end
        send3(OP_ADD, 32'd999, 32'd0, 1'b1);
        wait3(e);
        checks++;
        if (bus3.rsp_data !== 32'd0 || bus3.rsp_z !== 1'b1) begin
            errors++;
            $display("FAIL acc_cleared data=%h z=%0b want 0 1",
                     bus3.rsp_data, bus3.rsp_z);
        end
        ack3();
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        int e;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (stat_ops1 !== 0 || stat_err1 !== 0) begin
            errors++;
            $display("FAIL stats_rst ops=%0d err=%0d want 0 0",
                     stat_ops1, stat_err1);
        end
        for (int i = 0; i < 3; i++) begin
            send1(OP_ADD, 32'd1, 32'd2, 1'b0);
            wait1(e);
            ack1();
        end
        send1(6'b000000, 32'd0, 32'd0, 1'b0);
        wait1(e);
        ack1();
        send1(6'b111111, 32'd0, 32'd0, 1'b0);
        wait1(e);
        ack1();
        checks++;
        if (stat_ops1 !== 2'd3 || stat_err1 !== 2'd2) begin
            errors++;
            $display("FAIL stats_count ops=%0d err=%0d want 3 2",
                     stat_ops1, stat_err1);
        end
        send1(OP_SUB, 32'd5, 32'd1, 1'b0);
        wait1(e);
        ack1();
        for (int i = 0; i < 2; i++) begin
            send1(6'b000001, 32'd0, 32'd0, 1'b0);
            wait1(e);
            ack1();
        end
        checks++;
        if (stat_ops1 !== 2'd3 || stat_err1 !== 2'd3) begin
            errors++;
            $display("FAIL stats_sat ops=%0d err=%0d want 3 3",
                     stat_ops1, stat_err1);
        end
    endtask
`endif

    initial begin
        bus1.cmd_valid = 1'b0;
        bus1.cmd_op = '0;
        bus1.cmd_a = '0;
        bus1.cmd_b = '0;
        bus1.cmd_use_acc = 1'b0;
        bus1.rsp_ready = 1'b0;
        bus3.cmd_valid = 1'b0;
        bus3.cmd_op = '0;
        bus3.cmd_a = '0;
        bus3.cmd_b = '0;
        bus3.cmd_use_acc = 1'b0;
        bus3.rsp_ready = 1'b0;
        test_reset();
        test_ne();
        test_add_acc();
        test_illegal();
        test_ops();
        test_backpressure();
        test_throughput();
        test_lat3();
        test_reset_exec();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
